// File: rtl/fb_scanout_if.sv
// Frame-buffer read port and buffer-swap handshake between fb_scanout
// (master) and the RAM / writer side (slave).
interface fb_scanout_if #(
  parameter int P_LOG2_RAM_DEPTH = 19
) ();
  logic                      i_swap_req;
  logic                      o_swap_ack;
  logic                      o_rd_en;
  logic [P_LOG2_RAM_DEPTH:0] o_rd_addr;
  logic                      i_rd_data;

  modport master (
    input  i_swap_req,
    input  i_rd_data,
    output o_swap_ack,
    output o_rd_en,
    output o_rd_addr
  );

  modport slave (
    output i_swap_req,
    output i_rd_data,
    input  o_swap_ack,
    input  o_rd_en,
    input  o_rd_addr
  );
endinterface

// File: rtl/fb_scanout.sv
// VGA-style scanout of a 1-bit double-buffered frame buffer: raster timing,
// one RAM read per visible pixel, and a per-frame buffer swap at vblank start.
module fb_scanout #(
  parameter int P_SCREEN_W       = 640,
  parameter int P_SCREEN_H       = 480,
  parameter int P_X_COORD_W      = 11,
  parameter int P_Y_COORD_W      = 11,
  parameter int P_LOG2_RAM_DEPTH = 19,
  parameter int P_CLK_DIV        = 4,
  parameter int P_H_TOTAL        = 800,
  parameter int P_H_SYNC_START   = 656,
  parameter int P_H_SYNC_END     = 751,
  parameter int P_V_TOTAL        = 525,
  parameter int P_V_SYNC_START   = 490,
  parameter int P_V_SYNC_END     = 491
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  fb_scanout_if.master           bus,
  output logic [P_X_COORD_W-1:0] o_hcounter,
  output logic [P_Y_COORD_W-1:0] o_vcounter,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_blank,
  output logic                   o_pixel_on
);

  localparam int DIV_W = (P_CLK_DIV > 2) ? $clog2(P_CLK_DIV) : 2;
  localparam int A_W   = P_LOG2_RAM_DEPTH;

  typedef logic [P_X_COORD_W-1:0] x_t;
  typedef logic [P_Y_COORD_W-1:0] y_t;
  typedef logic [DIV_W-1:0]       div_t;

  localparam div_t DIV_LAST = div_t'(P_CLK_DIV - 1);
  localparam x_t   H_LAST   = x_t'(P_H_TOTAL - 1);
  localparam x_t   H_VIS    = x_t'(P_SCREEN_W);
  localparam x_t   HS_START = x_t'(P_H_SYNC_START);
  localparam x_t   HS_END   = x_t'(P_H_SYNC_END);
  localparam y_t   V_LAST   = y_t'(P_V_TOTAL - 1);
  localparam y_t   V_VIS    = y_t'(P_SCREEN_H);
  localparam y_t   VS_START = y_t'(P_V_SYNC_START);
  localparam y_t   VS_END   = y_t'(P_V_SYNC_END);

  div_t           div_q, div_d;
  x_t             scan_h_q, scan_h_d;
  y_t             scan_v_q, scan_v_d;
  x_t             h_q, h_d;
  y_t             v_q, v_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           blank_q, blank_d;
  logic           rd_en_q, rd_en_d;
  logic [A_W:0]   rd_addr_q, rd_addr_d;
  logic           buf_sel_q, buf_sel_d;
  logic           swap_ack_q, swap_ack_d;
  logic           tick1_q, tick1_d;
  logic           tick2_q, tick2_d;
  logic           pixel_q, pixel_d;

  logic           tick;
  logic           scan_vis;
  logic           vblank_start;
  logic [A_W-1:0] pix_addr;

  // scan_h/scan_v is the position that the next tick presents on the outputs,
  // so the first tick after reset shows (0,0) and issues its read.
  always_comb begin
    tick         = (div_q == DIV_LAST);
    scan_vis     = (scan_h_q < H_VIS) && (scan_v_q < V_VIS);
    vblank_start = (scan_h_q == '0) && (scan_v_q == V_VIS);
    pix_addr     = A_W'(scan_v_q) * A_W'(P_SCREEN_W) + A_W'(scan_h_q);

    div_d      = tick ? '0 : div_q + 1'b1;
    scan_h_d   = scan_h_q;
    scan_v_d   = scan_v_q;
    h_d        = h_q;
    v_d        = v_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    blank_d    = blank_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    buf_sel_d  = buf_sel_q;
    swap_ack_d = 1'b0;

    if (tick) begin
      h_d     = scan_h_q;
      v_d     = scan_v_q;
      hsync_d = !((scan_h_q >= HS_START) && (scan_h_q <= HS_END));
      vsync_d = !((scan_v_q >= VS_START) && (scan_v_q <= VS_END));
      blank_d = !scan_vis;
      rd_en_d = scan_vis;
      if (scan_vis) begin
        rd_addr_d = {buf_sel_q, pix_addr};
      end
      if (vblank_start && bus.i_swap_req) begin
        buf_sel_d  = !buf_sel_q;
        swap_ack_d = 1'b1;
      end
      if (scan_h_q == H_LAST) begin
        scan_h_d = '0;
        scan_v_d = (scan_v_q == V_LAST) ? '0 : scan_v_q + 1'b1;
      end else begin
        scan_h_d = scan_h_q + 1'b1;
      end
    end

    // Pixel lands two clocks after its tick; blank_q still describes that
    // pixel because the next tick is at least three clocks away.
    tick1_d = tick;
    tick2_d = tick1_q;
    pixel_d = pixel_q;
    if (tick2_q) begin
      pixel_d = !blank_q && bus.i_rd_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q      <= '0;
      scan_h_q   <= '0;
      scan_v_q   <= '0;
      h_q        <= '0;
      v_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      blank_q    <= 1'b1;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      buf_sel_q  <= 1'b0;
      swap_ack_q <= 1'b0;
      tick1_q    <= 1'b0;
      tick2_q    <= 1'b0;
      pixel_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      scan_h_q   <= scan_h_d;
      scan_v_q   <= scan_v_d;
      h_q        <= h_d;
      v_q        <= v_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      blank_q    <= blank_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      buf_sel_q  <= buf_sel_d;
      swap_ack_q <= swap_ack_d;
      tick1_q    <= tick1_d;
      tick2_q    <= tick2_d;
      pixel_q    <= pixel_d;
    end
  end

  assign o_hcounter     = h_q;
  assign o_vcounter     = v_q;
  assign o_hsync        = hsync_q;
  assign o_vsync        = vsync_q;
  assign o_blank        = blank_q;
  assign o_pixel_on     = pixel_q;
  assign bus.o_rd_en    = rd_en_q;
  assign bus.o_rd_addr  = rd_addr_q;
  assign bus.o_swap_ack = swap_ack_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a shrunken raster: cycle-accurate arithmetic model
// compared every clock, plus directed swap / reset / timing scenarios.
module tb_fb_scanout;

  localparam int W   = 16;
  localparam int H   = 12;
  localparam int XW  = 6;
  localparam int YW  = 6;
  localparam int AW  = 8;
  localparam int D   = 3;
  localparam int HT  = 24;
  localparam int VT  = 16;
  localparam int HS0 = 18;
  localparam int HS1 = 20;
  localparam int VS0 = 13;
  localparam int VS1 = 14;
  localparam int FRAME_CLKS = HT * VT * D;
  localparam int PW  = 2 + (AW + 1) + XW + YW + 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          swap_req = 1'b0;
  logic          ram_q;
  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  logic          hsync, vsync, blank, pixel_on;
  logic          mem [0:(1<<(AW+1))-1];

  int checks   = 0;
  int failures = 0;

  fb_scanout_if #(.P_LOG2_RAM_DEPTH(AW)) bus ();

  assign bus.i_swap_req = swap_req;
  assign bus.i_rd_data  = ram_q;

  fb_scanout #(
    .P_SCREEN_W(W), .P_SCREEN_H(H), .P_X_COORD_W(XW), .P_Y_COORD_W(YW),
    .P_LOG2_RAM_DEPTH(AW), .P_CLK_DIV(D),
    .P_H_TOTAL(HT), .P_H_SYNC_START(HS0), .P_H_SYNC_END(HS1),
    .P_V_TOTAL(VT), .P_V_SYNC_START(VS0), .P_V_SYNC_END(VS1)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .bus        (bus.master),
    .o_hcounter (hcnt),
    .o_vcounter (vcnt),
    .o_hsync    (hsync),
    .o_vsync    (vsync),
    .o_blank    (blank),
    .o_pixel_on (pixel_on)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data valid the clock after the read strobe.
  always @(posedge clk) begin
    if (bus.o_rd_en) ram_q <= mem[bus.o_rd_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: everything derives from clocks elapsed since reset release.
  int   cyc = 0, pix_due = -1, exp_h = 0, exp_v = 0, exp_addr = 0, p = 0;
  logic exp_hs = 1'b1, exp_vs = 1'b1, exp_blank = 1'b1, exp_rd_en = 1'b0;
  logic exp_pix = 1'b0, exp_ack = 1'b0, mbuf = 1'b0, pix_val = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc = 0; pix_due = -1; exp_h = 0; exp_v = 0; exp_addr = 0;
      exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b1; exp_rd_en = 1'b0;
      exp_pix = 1'b0; exp_ack = 1'b0; mbuf = 1'b0;
    end else begin
      cyc++;
      exp_ack   = 1'b0;
      exp_rd_en = 1'b0;
      if (cyc % D == 0) begin
        p         = (cyc / D - 1) % (HT * VT);
        exp_h     = p % HT;
        exp_v     = p / HT;
        exp_hs    = !(exp_h >= HS0 && exp_h <= HS1);
        exp_vs    = !(exp_v >= VS0 && exp_v <= VS1);
        exp_blank = (exp_h >= W) || (exp_v >= H);
        if (exp_h == 0 && exp_v == H && swap_req) begin
          mbuf    = !mbuf;
          exp_ack = 1'b1;
        end
        if (!exp_blank) begin
          exp_rd_en = 1'b1;
          exp_addr  = (mbuf ? (1 << AW) : 0) + exp_v * W + exp_h;
        end
        pix_val = exp_blank ? 1'b0 : mem[exp_addr];
        pix_due = cyc + 2;
      end
      if (cyc == pix_due) exp_pix = pix_val;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    logic [PW-1:0] act_v, exp_v_pk;
    @(negedge clk);
    act_v    = {bus.o_swap_ack, bus.o_rd_en, bus.o_rd_addr, hcnt, vcnt,
                hsync, vsync, blank, pixel_on};
    exp_v_pk = {exp_ack, exp_rd_en, (AW+1)'(exp_addr), XW'(exp_h), YW'(exp_v),
                exp_hs, exp_vs, exp_blank, exp_pix};
    checkOutput("cycle_outputs", 64'(act_v), 64'(exp_v_pk));
  end

  task automatic waitPos(input int h, input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(hcnt) == h && int'(vcnt) == v) && n < 3 * FRAME_CLKS);
    checkOutput("wait_pos_reached", 64'(int'(hcnt) == h && int'(vcnt) == v), 64'd1);
  endtask

  task automatic waitAck(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_swap_ack && n < 3 * FRAME_CLKS);
    checkOutput("ack_seen", 64'(bus.o_swap_ack), 64'd1);
  endtask

  task automatic countAcks(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.o_swap_ack) cnt++;
    end
  endtask

  task automatic firstRead(output int n, output logic msb, output int h, output int v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_rd_en && n < 3 * FRAME_CLKS);
    checkOutput("read_seen", 64'(bus.o_rd_en), 64'd1);
    msb = bus.o_rd_addr[AW];
    h   = int'(hcnt);
    v   = int'(vcnt);
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.o_swap_ack && $urandom_range(0, 1) == 1) swap_req = 1'b0;
      else if ($urandom_range(0, 149) == 0) swap_req = !swap_req;
    end
  endtask

  initial begin
    int   n, cnt, rd_cyc, rise_cyc, rise_h, rise_v, high_cnt, bad_cnt;
    int   hs_low, vs_low, fall_cnt, fall0, fall1;
    logic msb, prev_pix, prev_vs;
    int   rh, rv;

    for (int i = 0; i < (1 << (AW + 1)); i++) mem[i] = 1'($urandom);

    // Reset values and first-tick latency
    repeat (3) @(negedge clk);
    checkOutput("reset_values",
                64'({bus.o_swap_ack, bus.o_rd_en, bus.o_rd_addr, hcnt, vcnt, hsync, vsync, blank, pixel_on}),
                64'({1'b0, 1'b0, 9'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("no_read_before_first_tick", 64'(bus.o_rd_en), 64'd0);
    @(negedge clk);
    checkOutput("first_tick_read", 64'({bus.o_rd_en, bus.o_rd_addr, hcnt, vcnt, blank}),
                64'({1'b1, 9'd0, 6'd0, 6'd0, 1'b0}));

    // Single lit pixel at (5,3)
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < (1 << (AW + 1)); i++) mem[i] = 1'b0;
    mem[3 * W + 5] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_cyc = -100; rise_cyc = -1; rise_h = -1; rise_v = -1;
    high_cnt = 0; bad_cnt = 0; prev_pix = 1'b0;
    for (int i = 0; i < FRAME_CLKS + 20; i++) begin
      @(negedge clk);
      if (bus.o_rd_en && bus.o_rd_addr == 9'd53) rd_cyc = i;
      if (pixel_on && !prev_pix) begin
        rise_cyc = i; rise_h = int'(hcnt); rise_v = int'(vcnt);
      end
      if (pixel_on) high_cnt++;
      if (bus.o_rd_en && (blank || int'(hcnt) >= W)) bad_cnt++;
      prev_pix = pixel_on;
    end
    checkOutput("lit_pixel_clocks", 64'(high_cnt), 64'd3);
    checkOutput("lit_pixel_latency", 64'(rise_cyc - rd_cyc), 64'd2);
    checkOutput("lit_pixel_h", 64'(rise_h), 64'd5);
    checkOutput("lit_pixel_v", 64'(rise_v), 64'd3);
    checkOutput("no_blank_reads", 64'(bad_cnt), 64'd0);

    // Swap requested mid-frame, held until ack
    waitPos(0, 5);
    swap_req = 1'b1;
    waitAck(n);
    checkOutput("ack_pos", 64'({hcnt, vcnt}), 64'({6'd0, 6'd12}));
    swap_req = 1'b0;
    @(negedge clk);
    checkOutput("ack_one_clock", 64'(bus.o_swap_ack), 64'd0);
    countAcks(FRAME_CLKS, cnt);
    checkOutput("single_ack", 64'(cnt), 64'd0);
    firstRead(n, msb, rh, rv);
    checkOutput("buf_sel_after_swap", 64'(msb), 64'd1);

    // Request raised after vblank start and dropped before the next one
    waitPos(0, 13);
    swap_req = 1'b1;
    waitPos(0, 0);
    swap_req = 1'b0;
    countAcks(FRAME_CLKS, cnt);
    checkOutput("late_drop_no_ack", 64'(cnt), 64'd0);
    firstRead(n, msb, rh, rv);
    checkOutput("buf_sel_unchanged", 64'(msb), 64'd1);

    // Request raised after vblank start and held: served one frame on
    waitPos(0, 13);
    swap_req = 1'b1;
    waitAck(n);
    checkOutput("held_ack_delay", 64'(n), 64'((VT - 13 + H) * HT * D));
    checkOutput("held_ack_pos", 64'({hcnt, vcnt}), 64'({6'd0, 6'd12}));
    swap_req = 1'b0;

    // Asynchronous reset mid-frame with a swap pending
    waitPos(10, 7);
    swap_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_values",
                64'({bus.o_swap_ack, bus.o_rd_en, bus.o_rd_addr, hcnt, vcnt, hsync, vsync, blank, pixel_on}),
                64'({1'b0, 1'b0, 9'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
    swap_req = 1'b0;
    for (int i = 0; i < (1 << (AW + 1)); i++) mem[i] = 1'($urandom);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    firstRead(n, msb, rh, rv);
    checkOutput("restart_latency", 64'(n), 64'(D));
    checkOutput("restart_pos_buf", 64'({msb, 6'(rh), 6'(rv)}), 64'({1'b0, 6'd0, 6'd0}));
    countAcks(FRAME_CLKS, cnt);
    checkOutput("reset_discards_swap", 64'(cnt), 64'd0);

    // Sync pulse widths and frame period
    waitPos(0, 0);
    hs_low = 0; vs_low = 0; fall_cnt = 0; fall0 = -1; fall1 = -1; prev_vs = vsync;
    for (int i = 0; i < 2 * FRAME_CLKS + 10; i++) begin
      @(negedge clk);
      if (i < FRAME_CLKS && !hsync) hs_low++;
      if (i < FRAME_CLKS && !vsync) vs_low++;
      if (prev_vs && !vsync) begin
        if (fall_cnt == 0) fall0 = i;
        else if (fall_cnt == 1) fall1 = i;
        fall_cnt++;
      end
      prev_vs = vsync;
    end
    checkOutput("hsync_low_ticks_per_line", 64'(hs_low / (D * VT)), 64'd3);
    checkOutput("vsync_low_lines", 64'(vs_low / (D * HT)), 64'd2);
    checkOutput("frame_period_clocks", 64'(fall1 - fall0), 64'd1152);

    // Randomized swap traffic over random frame-buffer contents
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < (1 << (AW + 1)); i++) mem[i] = 1'($urandom);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(5 * FRAME_CLKS);
    swap_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter P_SCREEN_W, default 640, visible pixels per line.
REQ-002 Parameter P_SCREEN_H, default 480, visible lines per frame.
REQ-003 Parameter P_X_COORD_W, default 11, width of the horizontal counter.
REQ-004 Parameter P_Y_COORD_W, default 11, width of the vertical counter.
REQ-005 Parameter P_LOG2_RAM_DEPTH, default 19, address width of one frame buffer.
REQ-006 Parameter P_CLK_DIV, default 4, system clocks per pixel; legal values are 3 or more.
REQ-007 Port i_clk, input, 1, system clock; all logic on its rising edge.
REQ-008 Port i_reset_n, input, 1, reset; asynchronous assertion, active-low.
REQ-009 Port i_swap_req, input, 1, level request from the writer to flip the displayed buffer.
REQ-010 Port o_swap_ack, output, 1, one-clock pulse when the flip takes effect.
REQ-011 Port o_rd_en, output, 1, one-clock frame-buffer read strobe.
REQ-012 Port o_rd_addr, output, P_LOG2_RAM_DEPTH+1, read address; MSB is the buffer select.
REQ-013 Port i_rd_data, input, 1, RAM read data, valid exactly 1 clock after o_rd_en.
REQ-014 Port o_hcounter, output, P_X_COORD_W, current pixel column.
REQ-015 Port o_vcounter, output, P_Y_COORD_W, current line.
REQ-016 Port o_hsync, output, 1, horizontal sync, active-low.
REQ-017 Port o_vsync, output, 1, vertical sync, active-low.
REQ-018 Port o_blank, output, 1, high outside the visible area.
REQ-019 Port o_pixel_on, output, 1, registered pixel value for VGA colour muxing.

Function
REQ-020 A divider counts 0..P_CLK_DIV-1; a pixel tick occurs when it wraps to 0.
REQ-021 o_hcounter shall advance on each tick, running 0..799, and wrap to 0.
REQ-022 o_vcounter shall advance when o_hcounter wraps, running 0..524, and wrap to 0.
REQ-023 Horizontal timing: o_hsync low for h 656..751; high otherwise.
REQ-024 Vertical timing: o_vsync low for v 490..491; high otherwise.
REQ-025 o_blank is high when h >= P_SCREEN_W or v >= P_SCREEN_H, and is registered together with the counters.
REQ-026 On the clock where visible counters (h,v) take effect, o_rd_en shall pulse high with o_rd_addr = {buf_sel, v*P_SCREEN_W + h}; the multiply is computed at full address width, without truncation before the add.
REQ-027 No read is issued for blanked positions; o_rd_addr holds its last value.
REQ-028 o_pixel_on is updated 2 clocks after the tick, to i_rd_data when visible and 0 when blanked; it holds until the next update. The fixed pixel latency is 2 clocks.
REQ-029 buf_sel is evaluated once per frame, on the tick where (h,v) becomes (0,P_SCREEN_H), which is the vblank start.
REQ-030 At that tick, if i_swap_req is high, buf_sel toggles and o_swap_ack pulses for exactly 1 clock; if i_swap_req is low, nothing happens.
REQ-031 If i_swap_req rises during vblank or the visible area, the swap waits for the next vblank start; at most one swap occurs per frame.
REQ-032 If i_swap_req stays high after the ack, it is treated as a new request at the following frame; the writer is responsible for deasserting it on ack.
REQ-033 A buffer flip never occurs mid-frame; all reads within a frame use the same buf_sel.

Reset
REQ-034 While i_reset_n is low, the following values apply: divider 0, counters 0, o_hsync 1, o_vsync 1, o_blank 1, o_pixel_on 0, o_rd_en 0, o_rd_addr 0, buf_sel 0, o_swap_ack 0.
REQ-035 On release of i_reset_n, the first tick occurs P_CLK_DIV clocks later, and scanning restarts at (0,0).
REQ-036 A reset asserted mid-frame aborts the frame immediately; a pending swap is discarded.

Verification
REQ-037 Free-run after reset, counting ticks: hsync low pulse is 96 ticks within an 800-tick line; vsync low pulse is 2 lines within a 525-line frame; frame length is 420000 ticks (1680000 clocks).
REQ-038 RAM model with 1 at address 640*10+20 and 0 elsewhere, buf_sel 0: o_pixel_on is high only for (h,v) = (20,10), 2 clocks after that tick; addresses of 640 or more per line never appear.
REQ-039 i_swap_req raised at v=100 and held until ack: o_swap_ack pulses once at (0,480); subsequent o_rd_addr MSB is 1; o_rd_en stays 0 throughout blanking.
REQ-040 i_swap_req raised at v=490 and dropped at v=0: no ack is given and buf_sel is unchanged; raised at v=490 and held: ack occurs at the next frame's (0,480).
REQ-041 i_reset_n pulsed low at (300,200) with a swap pending: all outputs take their reset values asynchronously, no ack is given, and scanning resumes at (0,0) with buf_sel 0.
REQ-042 Run with P_CLK_DIV=3: each o_rd_en is followed by o_pixel_on updating exactly 2 clocks later, with no overlap between pixels.
